// File: rtl/periph_bus_arbiter_pkg.sv
// Shared types and constants for the peripheral bus arbiter.
package periph_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int         CNT_W     = 8;
    localparam logic [7:0] ERR_RDATA = 8'hFF;

endpackage

// File: rtl/periph_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index after 'last', modulo NUM_M.
module rr_pick #(
    parameter int NUM_M = 2,
    parameter int IDX_W = 1
) (
    input  logic [NUM_M-1:0] pending,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    int j;

    // Walk from farthest to nearest so the nearest pending index is written last.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        j      = 0;
        for (int k = NUM_M; k >= 1; k--) begin
            j = (int'(last) + k) % NUM_M;
            if (pending[j]) begin
                valid  = 1'b1;
                winner = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing one strobe/ready peripheral port among NUM_M requesters.
// state    | meaning
// IDLE     | pick a pending requester, latch its op/addr/wdata
// ISSUE    | one-cycle s_read/s_write strobe, clear timeout counter
// WAIT     | wait for matching ready or timeout
// DONE     | one-cycle m_done to the winner with m_err/m_rdata
module periph_bus_arbiter #(
    parameter int NUM_M     = 2,
    parameter int SIZE_ADDR = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_M-1:0]           m_read,
    input  logic [NUM_M-1:0]           m_write,
    input  logic [NUM_M*SIZE_ADDR-1:0] m_addr,
    input  logic [NUM_M*8-1:0]         m_wdata,
    output logic [NUM_M-1:0]           m_done,
    output logic                       m_err,
    output logic [7:0]                 m_rdata,
    output logic                       s_read,
    output logic                       s_write,
    output logic [SIZE_ADDR-1:0]       s_addr,
    output logic [7:0]                 s_wdata,
    input  logic [7:0]                 s_rdata,
    input  logic                       s_ready_r,
    input  logic                       s_ready_w
);
    import periph_bus_arbiter_pkg::*;

    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     grant_q, last_q, pick_idx;
    logic                 pick_vld;
    logic                 op_w_q;
    logic [SIZE_ADDR-1:0] addr_q;
    logic [7:0]           wdata_q, rdata_q;
    logic                 err_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ready_hit, tmo_hit;

    rr_pick #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_rr_pick (
        .pending (m_read | m_write),
        .last    (last_q),
        .winner  (pick_idx),
        .valid   (pick_vld)
    );

    // Only the ready matching the latched op completes the transaction.
    assign ready_hit = op_w_q ? s_ready_w : s_ready_r;
    assign tmo_hit   = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_vld) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (ready_hit || tmo_hit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_M - 1);
            op_w_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick_idx;
                        last_q  <= pick_idx;
                        op_w_q  <= m_write[pick_idx];
                        addr_q  <= m_addr[int'(pick_idx)*SIZE_ADDR +: SIZE_ADDR];
                        wdata_q <= m_wdata[int'(pick_idx)*8 +: 8];
                    end
                end
                ST_ISSUE: cnt_q <= '0;
                ST_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (ready_hit) begin
                        err_q   <= 1'b0;
                        rdata_q <= op_w_q ? 8'h00 : s_rdata;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= ERR_RDATA;
                    end
                end
                ST_DONE: begin
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m_done  = '0;
        s_read  = 1'b0;
        s_write = 1'b0;
        if (state_q == ST_ISSUE) begin
            s_read  = ~op_w_q;
            s_write = op_w_q;
        end
        if (state_q == ST_DONE) m_done[grant_q] = 1'b1;
    end

    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign m_err   = err_q;
    assign m_rdata = rdata_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Randomized bench: transaction-timeline reference model of the round-robin peripheral arbiter.
module tb_periph_bus_arbiter;

    localparam int NM = 3;
    localparam int AW = 2;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NM-1:0]    m_read, m_write, m_done;
    logic [NM*AW-1:0] m_addr;
    logic [NM*8-1:0]  m_wdata;
    logic             m_err;
    logic [7:0]       m_rdata;
    logic             s_read, s_write;
    logic [AW-1:0]    s_addr;
    logic [7:0]       s_wdata, s_rdata;
    logic             s_ready_r, s_ready_w;

    periph_bus_arbiter #(.NUM_M(NM), .SIZE_ADDR(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_done(m_done), .m_err(m_err), .m_rdata(m_rdata),
        .s_read(s_read), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready_r(s_ready_r), .s_ready_w(s_ready_w)
    );

    int n_vec = 0;
    int n_bad = 0;
    int t = 0;

    // Requester-side view
    bit            act[NM];
    bit            req_r[NM];
    bit            req_w[NM];
    logic [AW-1:0] rq_addr[NM];
    logic [7:0]    rq_wd[NM];

    // Reference timeline of the transaction in flight
    int            last_g, grant, strobe_cyc, done_cyc, free_from, ready_k;
    bit            g_w, exp_err;
    logic [AW-1:0] g_addr;
    logic [7:0]    g_wd, exp_rd;
    bit            just_rst, force_all;
    int            n_resets;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, t, got, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NM; i++) begin
            m_read[i]            = act[i] && req_r[i];
            m_write[i]           = act[i] && req_w[i];
            m_addr[i*AW +: AW]   = rq_addr[i];
            m_wdata[i*8 +: 8]    = rq_wd[i];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NM; i++) act[i] = 1'b0;
        last_g     = NM - 1;
        strobe_cyc = -1;
        done_cyc   = -1;
        grant      = 0;
        exp_err    = 1'b0;
        exp_rd     = 8'h00;
    endtask

    task automatic check_cycle();
        bit            is_s, is_d;
        logic [NM-1:0] ed;
        is_s = (t == strobe_cyc);
        is_d = (t == done_cyc);
        ed   = '0;
        if (is_d) ed[grant] = 1'b1;
        chk("s_read", 32'(s_read), 32'(is_s && !g_w));
        chk("s_write", 32'(s_write), 32'(is_s && g_w));
        chk("m_done", 32'(m_done), 32'(ed));
        if (is_s) begin
            chk("s_addr", 32'(s_addr), 32'(g_addr));
            chk("s_wdata", 32'(s_wdata), 32'(g_wd));
        end
        if (is_d) begin
            chk("m_err", 32'(m_err), 32'(exp_err));
            if (!g_w || exp_err) chk("m_rdata", 32'(m_rdata), 32'(exp_rd));
        end else begin
            chk("err_rdata_idle", {23'd0, m_err, m_rdata}, 32'd0);
        end
    endtask

    task automatic step_requests();
        int op;
        for (int i = 0; i < NM; i++) begin
            if (act[i] && t == done_cyc && grant == i) begin
                act[i] = 1'b0;
            end else if (act[i] && grant == i && t >= strobe_cyc && t < done_cyc) begin
                // Changing inputs after the grant must not affect the latched transaction
                if ($urandom_range(0, 3) == 0) begin
                    rq_addr[i] = AW'($urandom);
                    rq_wd[i]   = 8'($urandom);
                end
            end else if (!act[i] && (force_all || $urandom_range(0, 2) == 0)) begin
                op         = int'($urandom_range(0, 2));
                act[i]     = 1'b1;
                req_r[i]   = (op != 1);
                req_w[i]   = (op != 0);
                rq_addr[i] = AW'($urandom);
                rq_wd[i]   = 8'($urandom);
            end
        end
    endtask

    task automatic step_arbiter();
        int j, sel;
        if (t < free_from) return;
        for (int k = 1; k <= NM; k++) begin
            j = (last_g + k) % NM;
            if (act[j]) begin
                grant      = j;
                last_g     = j;
                g_w        = req_w[j];
                g_addr     = rq_addr[j];
                g_wd       = rq_wd[j];
                strobe_cyc = t + 1;
                sel        = int'($urandom_range(0, 5));
                case (sel)
                    0, 1:    ready_k = 1;
                    2:       ready_k = 2;
                    3:       ready_k = 3;
                    4:       ready_k = TO;
                    default: ready_k = 0;
                endcase
                exp_err   = (ready_k == 0);
                exp_rd    = exp_err ? 8'hFF : 8'h00;
                done_cyc  = strobe_cyc + ((ready_k != 0) ? ready_k : TO) + 1;
                free_from = done_cyc + 1;
                break;
            end
        end
    endtask

    task automatic step_peripheral();
        bit in_wait;
        int k;
        s_rdata = 8'($urandom);
        in_wait = (strobe_cyc >= 0) && (t > strobe_cyc) && (t < done_cyc);
        k       = t - strobe_cyc;
        if (in_wait && k == ready_k) begin
            if (g_w) begin
                s_ready_w = 1'b1;
                s_ready_r = 1'($urandom_range(0, 1));
            end else begin
                s_ready_r = 1'b1;
                s_ready_w = 1'($urandom_range(0, 1));
                exp_rd    = s_rdata;
            end
        end else if (in_wait) begin
            s_ready_r = g_w ? 1'($urandom_range(0, 1)) : 1'b0;
            s_ready_w = g_w ? 1'b0 : 1'($urandom_range(0, 1));
        end else begin
            s_ready_r = ($urandom_range(0, 3) == 0);
            s_ready_w = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        m_read    = '0;
        m_write   = '0;
        m_addr    = '0;
        m_wdata   = '0;
        s_rdata   = '0;
        s_ready_r = 1'b0;
        s_ready_w = 1'b0;
        for (int i = 0; i < NM; i++) begin
            req_r[i]   = 1'b0;
            req_w[i]   = 1'b0;
            rq_addr[i] = '0;
            rq_wd[i]   = '0;
        end
        model_reset();
        free_from = 0;
        just_rst  = 1'b1;
        force_all = 1'b0;
        n_resets  = 0;
        g_w       = 1'b0;
        g_addr    = '0;
        g_wd      = '0;
        ready_k   = 0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);

        for (int iter = 0; iter < 2400; iter++) begin
            @(negedge clk);
            check_cycle();
            if (just_rst) begin
                chk("rst_s_addr", 32'(s_addr), 32'd0);
                chk("rst_s_wdata", 32'(s_wdata), 32'd0);
                reset     = 1'b0;
                just_rst  = 1'b0;
                force_all = 1'b1;
                free_from = t;
            end else if (n_resets < 2 && iter >= 700 * (n_resets + 1) &&
                         t > strobe_cyc && t < done_cyc) begin
                // Abandon the transaction in WAIT; every requester restarts afterwards
                reset = 1'b1;
                model_reset();
                drive_reqs();
                just_rst = 1'b1;
                n_resets++;
                t++;
                continue;
            end
            step_requests();
            step_arbiter();
            step_peripheral();
            drive_reqs();
            force_all = 1'b0;
            t++;
        end

        chk("mid_op_resets", 32'(n_resets), 32'd2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
